// File: rtl/sarray_mem_rsp_pkg.sv
// Shared widths for the systolic-array memory responder.
// Defaults match the sarray load/store interface.
package sarray_mem_rsp_pkg;

  localparam int ADDR_WIDTH         = 64;
  localparam int SARRAY_LOAD_WIDTH  = 2048;
  localparam int SARRAY_STORE_WIDTH = 2048;
  localparam int SARRAY_LINE_SHIFT  = 8;

endpackage

// File: rtl/sarray_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Storage is not reset; only pointers and count are.
module sarray_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty_o  = (count_q == '0);
    do_push  = push_i && !full;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    head_o   = mem_q[rd_ptr_q];
    count_o  = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sarray_mem_rsp.sv
// Memory-side responder for the sarray AR/R/AW channels.
// 1R1W line memory, one registered read stage, credit-gated FIFO.
module sarray_mem_rsp #(
  parameter int ADDR_WIDTH  = sarray_mem_rsp_pkg::ADDR_WIDTH,
  parameter int LOAD_WIDTH  = sarray_mem_rsp_pkg::SARRAY_LOAD_WIDTH,
  parameter int STORE_WIDTH = sarray_mem_rsp_pkg::SARRAY_STORE_WIDTH,
  parameter int LINE_SHIFT  = sarray_mem_rsp_pkg::SARRAY_LINE_SHIFT,
  parameter int DEPTH       = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sarray_ar_valid_i,
  output logic                          sarray_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]         sarray_ar_addr_i,
  output logic                          sarray_r_valid_o,
  input  logic                          sarray_r_ready_i,
  output logic [LOAD_WIDTH-1:0]         sarray_r_data_o,
  input  logic                          sarray_aw_valid_i,
  output logic                          sarray_aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]         sarray_aw_addr_i,
  input  logic [STORE_WIDTH-1:0]        sarray_aw_data_i,
  output logic [$clog2(FIFO_DEPTH):0]   rd_outstanding_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int HI_LO = LINE_SHIFT + IDX_W;

  logic [LOAD_WIDTH-1:0] mem_q [DEPTH];
  logic [LOAD_WIDTH-1:0] rd_data_q;
  logic                  infl_q, infl_d;

  logic [IDX_W-1:0]      ar_idx;
  logic [IDX_W-1:0]      aw_idx;
  logic                  ar_fire;
  logic                  aw_fire;
  logic                  r_fire;

  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W-1:0]      occ;
  logic                  fifo_empty;
  logic [LOAD_WIDTH-1:0] fifo_head;

  // Address bits outside the line index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sarray_ar_addr_i[ADDR_WIDTH-1:HI_LO],
                              sarray_ar_addr_i[LINE_SHIFT-1:0],
                              sarray_aw_addr_i[ADDR_WIDTH-1:HI_LO],
                              sarray_aw_addr_i[LINE_SHIFT-1:0]};

  always_comb begin
    ar_idx            = sarray_ar_addr_i[LINE_SHIFT +: IDX_W];
    aw_idx            = sarray_aw_addr_i[LINE_SHIFT +: IDX_W];
    occ               = fifo_cnt + CNT_W'(infl_q);
    sarray_ar_ready_o = (occ < CNT_W'(FIFO_DEPTH));
    sarray_aw_ready_o = 1'b1;
    sarray_r_valid_o  = !fifo_empty;
    sarray_r_data_o   = fifo_empty ? '0 : fifo_head;
    ar_fire           = sarray_ar_valid_i && sarray_ar_ready_o;
    aw_fire           = sarray_aw_valid_i && sarray_aw_ready_o;
    r_fire            = sarray_r_valid_o && sarray_r_ready_i;
    infl_d            = ar_fire;
    rd_outstanding_o  = occ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) infl_q <= 1'b0;
    else        infl_q <= infl_d;
  end

  // Read sees pre-write contents on a same-cycle index collision.
  always_ff @(posedge clk) begin
    if (aw_fire) mem_q[aw_idx] <= LOAD_WIDTH'(sarray_aw_data_i);
    if (ar_fire) rd_data_q <= mem_q[ar_idx];
  end

  sarray_rsp_fifo #(
    .WIDTH (LOAD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (infl_q),
    .push_data_i (rd_data_q),
    .pop_i       (r_fire),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

endmodule
